// File: rtl/da_rom_if.sv
// rtl/da_rom_if.sv - loader, engine and SRAM signal bundle for the DA ROM sequencer
interface da_rom_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 16
);
    logic              cload;
    logic              cvalid;
    logic [DATA_W-1:0] cdata;
    logic              cready;
    logic              load_done;
    logic              rd_req;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_valid;
    logic [DATA_W-1:0] rd_data;
    logic              err_rd;
    logic              mem_cen;
    logic              mem_wen;
    logic [ADDR_W-1:0] mem_a;
    logic [DATA_W-1:0] mem_d;
    logic [DATA_W-1:0] mem_q;

    modport slave (
        input  cload, cvalid, cdata, rd_req, rd_addr, mem_q,
        output cready, load_done, rd_valid, rd_data, err_rd,
               mem_cen, mem_wen, mem_a, mem_d
    );

    modport master (
        output cload, cvalid, cdata, rd_req, rd_addr, mem_q,
        input  cready, load_done, rd_valid, rd_data, err_rd,
               mem_cen, mem_wen, mem_a, mem_d
    );
endinterface

// File: rtl/da_rom_sequencer.sv
// rtl/da_rom_sequencer.sv - loads the DA partial-sum ROM, locks it, then serves pipelined reads
module da_rom_sequencer #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 16
) (
    input  logic     clk,
    input  logic     reset,
    da_rom_if.slave  bus
);
    typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, ARMED = 2'd2} state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

    state_t            state, state_n;
    logic [ADDR_W-1:0] wr_ptr, wr_ptr_n;
    logic              load_done_n, cready_n, err_n, cen_n, wen_n, rd_issue;
    logic [ADDR_W-1:0] a_n;
    logic [DATA_W-1:0] d_n;
    // rd_p1: read strobe on the SRAM pins now; rd_p2: mem_q holds that word now
    logic              rd_p1, rd_p2;

    always_comb begin
        state_n     = state;
        wr_ptr_n    = wr_ptr;
        load_done_n = bus.load_done;
        cen_n       = 1'b1;
        wen_n       = 1'b1;
        a_n         = bus.mem_a;
        d_n         = bus.mem_d;
        rd_issue    = 1'b0;
        case (state)
            IDLE: begin
                if (bus.cload) begin
                    state_n     = LOAD;
                    wr_ptr_n    = '0;
                    load_done_n = 1'b0;
                end
            end
            LOAD: begin
                if (!bus.cload) begin
                    state_n     = IDLE;
                    load_done_n = 1'b0;
                end else if (bus.cvalid && bus.cready) begin
                    cen_n    = 1'b0;
                    wen_n    = 1'b0;
                    a_n      = wr_ptr;
                    d_n      = bus.cdata;
                    wr_ptr_n = wr_ptr + 1'b1;
                    if (wr_ptr == LAST_ADDR) begin
                        state_n     = ARMED;
                        load_done_n = 1'b1;
                    end
                end
            end
            ARMED: begin
                // A reload request wins; a read issued alongside it is dropped
                if (bus.cload) begin
                    state_n     = LOAD;
                    wr_ptr_n    = '0;
                    load_done_n = 1'b0;
                end else if (bus.rd_req) begin
                    cen_n    = 1'b0;
                    a_n      = bus.rd_addr;
                    rd_issue = 1'b1;
                end
            end
            default: begin
                state_n     = IDLE;
                load_done_n = 1'b0;
            end
        endcase
        err_n    = bus.rd_req && !rd_issue;
        cready_n = (state_n == LOAD) && bus.cload;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            wr_ptr        <= '0;
            bus.cready    <= 1'b0;
            bus.load_done <= 1'b0;
            bus.rd_valid  <= 1'b0;
            bus.rd_data   <= '0;
            bus.err_rd    <= 1'b0;
            bus.mem_cen   <= 1'b1;
            bus.mem_wen   <= 1'b1;
            bus.mem_a     <= '0;
            bus.mem_d     <= '0;
            rd_p1         <= 1'b0;
            rd_p2         <= 1'b0;
        end else begin
            state         <= state_n;
            wr_ptr        <= wr_ptr_n;
            bus.cready    <= cready_n;
            bus.load_done <= load_done_n;
            bus.err_rd    <= err_n;
            bus.mem_cen   <= cen_n;
            bus.mem_wen   <= wen_n;
            bus.mem_a     <= a_n;
            bus.mem_d     <= d_n;
            rd_p1         <= rd_issue;
            rd_p2         <= rd_p1;
            bus.rd_valid  <= rd_p2;
            if (rd_p2) begin
                bus.rd_data <= bus.mem_q;
            end
        end
    end
endmodule

// File: tb/tb_da_rom_sequencer.sv
// tb/tb_da_rom_sequencer.sv - scoreboard bench for da_rom_sequencer with a behavioural SRAM
module tb_da_rom_sequencer;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;

    da_rom_if #(.ADDR_W(4), .DATA_W(16)) bus ();

    da_rom_sequencer #(.ADDR_W(4), .DATA_W(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic [15:0] sram [16];
    always @(posedge clk) begin
        if (!bus.mem_cen) begin
            if (!bus.mem_wen) sram[bus.mem_a] <= bus.mem_d;
            else              bus.mem_q <= sram[bus.mem_a];
        end
    end

    typedef struct {
        logic        wen;
        logic [3:0]  a;
        logic [15:0] d;
        int          due;
    } strobe_t;
    typedef struct {
        logic [15:0] d;
        int          due;
    } rd_t;

    strobe_t sq[$];
    rd_t     rq[$];
    int      eq[$];

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", nm, got, exp, cyc);
        end
    endtask

    task automatic flag(input string nm);
        vectors++;
        miscompares++;
        $display("FAIL %s (cycle %0d)", nm, cyc);
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (!bus.mem_cen) begin
                if (sq.size() == 0) begin
                    flag($sformatf("unexpected_strobe wen=%0b a=%0h", bus.mem_wen, bus.mem_a));
                end else begin
                    strobe_t s;
                    s = sq.pop_front();
                    chk("strobe_wen", 32'(bus.mem_wen), 32'(s.wen));
                    chk("strobe_addr", 32'(bus.mem_a), 32'(s.a));
                    if (!s.wen) chk("strobe_wdata", 32'(bus.mem_d), 32'(s.d));
                    chk("strobe_cycle", cyc, s.due);
                end
            end else if (sq.size() != 0 && sq[0].due <= cyc) begin
                void'(sq.pop_front());
                flag("missing_strobe");
            end
            if (bus.rd_valid) begin
                if (rq.size() == 0) begin
                    flag($sformatf("unexpected_rd_valid data=%0h", bus.rd_data));
                end else begin
                    rd_t r;
                    r = rq.pop_front();
                    chk("rd_data", 32'(bus.rd_data), 32'(r.d));
                    chk("rd_latency", cyc, r.due);
                end
            end else if (rq.size() != 0 && rq[0].due <= cyc) begin
                void'(rq.pop_front());
                flag("missing_rd_valid");
            end
            if (bus.err_rd) begin
                if (eq.size() == 0) flag("unexpected_err_rd");
                else chk("err_rd_cycle", cyc, eq.pop_front());
            end else if (eq.size() != 0 && eq[0] <= cyc) begin
                void'(eq.pop_front());
                flag("missing_err_rd");
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_cready"},    32'(bus.cready),    0);
        chk({tag, "_load_done"}, 32'(bus.load_done), 0);
        chk({tag, "_rd_valid"},  32'(bus.rd_valid),  0);
        chk({tag, "_rd_data"},   32'(bus.rd_data),   0);
        chk({tag, "_err_rd"},    32'(bus.err_rd),    0);
        chk({tag, "_mem_cen"},   32'(bus.mem_cen),   1);
        chk({tag, "_mem_wen"},   32'(bus.mem_wen),   1);
        chk({tag, "_mem_a"},     32'(bus.mem_a),     0);
        chk({tag, "_mem_d"},     32'(bus.mem_d),     0);
    endtask

    task automatic load_seq(input int n, input logic [15:0] base, input bit bubble);
        for (int i = 0; i < n; i++) begin
            bus.cvalid = 1'b1;
            bus.cdata  = base + 16'(i);
            sq.push_back('{1'b0, 4'(i), base + 16'(i), cyc + 1});
            step();
            if (bubble) begin
                bus.cvalid = 1'b0;
                step();
            end
        end
        bus.cvalid = 1'b0;
    endtask

    task automatic issue_read(input logic [3:0] a, input logic [15:0] exp);
        bus.rd_req  = 1'b1;
        bus.rd_addr = a;
        sq.push_back('{1'b1, a, 16'h0, cyc + 1});
        rq.push_back('{exp, cyc + 3});
    endtask

    initial begin
        bus.cload = 0; bus.cvalid = 0; bus.cdata = 0;
        bus.rd_req = 0; bus.rd_addr = 0; bus.mem_q = 0;
        repeat (3) step();
        check_reset_vals("por");
        reset = 1'b0;

        // T1: reset in the middle of a load
        bus.cload = 1'b1;
        step();
        chk("t1_cready_load", 32'(bus.cready), 1);
        load_seq(5, 16'h5000, 1'b0);
        @(negedge clk);
        #2 reset = 1'b1;
        #1 check_reset_vals("t1_async");
        bus.cload = 1'b0;
        step();
        step();
        reset = 1'b0;

        // T2: full load; cvalid during the IDLE->LOAD cycle must be ignored
        bus.cload  = 1'b1;
        bus.cvalid = 1'b1;
        bus.cdata  = 16'hDEAD;
        step();
        bus.cvalid = 1'b0;
        chk("t2_load_done_in_load", 32'(bus.load_done), 0);
        load_seq(16, 16'h1000, 1'b0);
        chk("t2_load_done", 32'(bus.load_done), 1);
        chk("t2_cready_after", 32'(bus.cready), 0);
        bus.cload = 1'b0;
        step();

        // T3: back-to-back reads
        issue_read(4'd3, 16'h1003);  step();
        issue_read(4'd7, 16'h1007);  step();
        issue_read(4'd15, 16'h100F); step();
        bus.rd_req = 1'b0;
        repeat (4) step();

        // T4: reload with bubbles, abort after 9 words, then a rejected read
        bus.cload = 1'b1;
        step();
        chk("t4_load_done_cleared", 32'(bus.load_done), 0);
        chk("t4_cready", 32'(bus.cready), 1);
        load_seq(9, 16'h2000, 1'b1);
        bus.cload = 1'b0;
        step();
        chk("t4_load_done_abort", 32'(bus.load_done), 0);
        chk("t4_cready_idle", 32'(bus.cready), 0);
        bus.rd_req  = 1'b1;
        bus.rd_addr = 4'd2;
        eq.push_back(cyc + 1);
        step();
        bus.rd_req = 1'b0;
        repeat (3) step();

        // T5: reload beats a simultaneous read; the earlier read still returns
        bus.cload = 1'b1;
        step();
        load_seq(16, 16'h3000, 1'b0);
        bus.cload = 1'b0;
        step();
        issue_read(4'd5, 16'h3005);
        step();
        bus.cload   = 1'b1;
        bus.rd_req  = 1'b1;
        bus.rd_addr = 4'd6;
        eq.push_back(cyc + 1);
        step();
        bus.rd_req = 1'b0;
        chk("t5_load_done", 32'(bus.load_done), 0);
        chk("t5_cready", 32'(bus.cready), 1);

        // T6: random cvalid / rd_req during load, then random reads
        begin
            int n = 0;
            while (n < 16) begin
                bus.cvalid  = 1'($urandom_range(0, 1));
                bus.rd_req  = ($urandom_range(0, 3) == 0);
                bus.rd_addr = 4'($urandom_range(0, 15));
                if (bus.cvalid) begin
                    bus.cdata = 16'h4000 + 16'(n);
                    sq.push_back('{1'b0, 4'(n), 16'h4000 + 16'(n), cyc + 1});
                    n++;
                end
                if (bus.rd_req) eq.push_back(cyc + 1);
                step();
            end
        end
        bus.cload  = 1'b0;
        bus.cvalid = 1'b0;
        bus.rd_req = 1'b0;
        chk("t6_load_done", 32'(bus.load_done), 1);
        for (int k = 0; k < 40; k++) begin
            bus.cvalid = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 2) != 0) begin
                logic [3:0] a;
                a = 4'($urandom_range(0, 15));
                issue_read(a, 16'h4000 + 16'(a));
            end else begin
                bus.rd_req = 1'b0;
            end
            step();
        end
        bus.rd_req = 1'b0;
        bus.cvalid = 1'b0;
        repeat (5) step();

        chk("drain_strobes", sq.size(), 0);
        chk("drain_reads", rq.size(), 0);
        chk("drain_errs", eq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
